// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM states, frame length and parity helper.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Scan-code consumer interface: FIFO head, occupancy, pop request and fault pulses.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();

    localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic               rd;
    logic [7:0]         data;
    logic               valid;
    logic [COUNT_W-1:0] count;
    logic               parity_err;
    logic               frame_err;
    logic               overflow;

    modport master (
        input  rd,
        output data, valid, count, parity_err, frame_err, overflow
    );

    modport slave (
        output rd,
        input  data, valid, count, parity_err, frame_err, overflow
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// Synchronises the raw PS/2 pins and debounces the clock line into a falling-edge strobe.
module ps2_sync_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_filt,
    output logic o_data_sync,
    output logic o_fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered clock only follows the synced line after DEBOUNCE_CYCLES steady samples.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (clk_sync_q != filt_q) begin
            if (cnt_q == DEB_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            clk_meta_q  <= i_ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= i_ps2_data;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign o_clk_filt  = filt_q;
    assign o_data_sync = data_sync_q;
    assign o_fall      = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame checking, inactivity timeout and a
// first-word-fall-through scan-code FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter bit          CHECK_PARITY    = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ps2_clk,
    input  logic          i_ps2_data,
    ps2_rx_fifo_if.master bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ps2_clk_filt, ps2_data_sync, ps2_fall, strobe;

    ps2_sync_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_filter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_clk_filt (ps2_clk_filt),
        .o_data_sync(ps2_data_sync),
        .o_fall     (ps2_fall)
    );

    // The filtered clock is always low on a genuine falling edge.
    assign strobe = ps2_fall & ~ps2_clk_filt;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit, push, perr_d, ferr_d, ovf_d;
    logic          perr_q, ferr_q, ovf_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, pop, wr_en;

    assign tmo_hit   = (state_q != StIdle) && !strobe && (tmo_cnt_q == TMO_LAST);
    assign tmo_cnt_d = (state_q == StIdle || strobe || tmo_hit) ? '0 : tmo_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (tmo_hit) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
        end else if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (!ps2_data_sync) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {ps2_data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = ps2_data_sync;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!ps2_data_sync) begin
                        ferr_d = 1'b1;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                        push   = !CHECK_PARITY;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = bus.rd & ~empty;
    // A pop on a full FIFO frees the slot the push lands in.
    assign wr_en = push & (~full | pop);
    assign ovf_d = push & full & ~pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_cnt_q <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_cnt_q <= tmo_cnt_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign bus.data       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.valid      = ~empty;
    assign bus.count      = wr_ptr_q - rd_ptr_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised bench for ps2_rx_fifo: two instances (parity checked / not checked)
// compared against a queue-based frame model.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int unsigned DEB   = 4;
    localparam int unsigned TMO   = 200;
    localparam int unsigned DEPTH = 4;
    localparam int          HALF  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic rd = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_a ();
    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_b ();
    assign bus_a.rd = rd;
    assign bus_b.rd = rd;

    ps2_rx_fifo #(
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data), .bus(bus_a)
    );

    ps2_rx_fifo #(
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observed pulse-cycle counts, index 0 = dut_a, 1 = dut_b.
    int perr_cnt[2];
    int ferr_cnt[2];
    int ovf_cnt[2];
    int exp_perr[2];
    int exp_ferr[2];
    int exp_ovf[2];
    logic [7:0] mq_a[$];
    logic [7:0] mq_b[$];

    always @(negedge clk) begin
        if (bus_a.parity_err) perr_cnt[0]++;
        if (bus_a.frame_err)  ferr_cnt[0]++;
        if (bus_a.overflow)   ovf_cnt[0]++;
        if (bus_b.parity_err) perr_cnt[1]++;
        if (bus_b.frame_err)  ferr_cnt[1]++;
        if (bus_b.overflow)   ovf_cnt[1]++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_push(input int i, input logic [7:0] b);
        if (i == 0) begin
            if (mq_a.size() < int'(DEPTH)) mq_a.push_back(b);
            else exp_ovf[0]++;
        end else begin
            if (mq_b.size() < int'(DEPTH)) mq_b.push_back(b);
            else exp_ovf[1]++;
        end
    endfunction

    // Outcome of one frame; partial frames are assumed to have been left to time out.
    function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop,
                                        input int nbits);
        for (int i = 0; i < 2; i++) begin
            if (nbits < PS2_FRAME_BITS || !stop) begin
                exp_ferr[i]++;
            end else if ((^{b, par}) == 1'b0) begin
                exp_perr[i]++;
                if (i == 1) model_push(i, b);
            end else begin
                model_push(i, b);
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] fa, fb;
        fa = (mq_a.size() > 0) ? mq_a[0] : 8'h00;
        fb = (mq_b.size() > 0) ? mq_b[0] : 8'h00;
        check_eq({tag, " a.count"}, 32'(bus_a.count), mq_a.size());
        check_eq({tag, " a.valid"}, 32'(bus_a.valid), 32'(mq_a.size() > 0));
        check_eq({tag, " a.data"}, 32'(bus_a.data), 32'(fa));
        check_eq({tag, " a.perr"}, perr_cnt[0], exp_perr[0]);
        check_eq({tag, " a.ferr"}, ferr_cnt[0], exp_ferr[0]);
        check_eq({tag, " a.ovf"}, ovf_cnt[0], exp_ovf[0]);
        check_eq({tag, " b.count"}, 32'(bus_b.count), mq_b.size());
        check_eq({tag, " b.valid"}, 32'(bus_b.valid), 32'(mq_b.size() > 0));
        check_eq({tag, " b.data"}, 32'(bus_b.data), 32'(fb));
        check_eq({tag, " b.perr"}, perr_cnt[1], exp_perr[1]);
        check_eq({tag, " b.ferr"}, ferr_cnt[1], exp_ferr[1]);
        check_eq({tag, " b.ovf"}, ovf_cnt[1], exp_ovf[1]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input bit glitch);
        logic [PS2_FRAME_BITS-1:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            ps2_data = bits[k];
            wait_cyc(8);
            if (glitch && k == 4) begin
                ps2_clk = 1'b0;
                wait_cyc(DEB - 1);
                ps2_clk = 1'b1;
            end
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(8);
            if (glitch && k == 4) begin
                ps2_clk = 1'b1;
                wait_cyc(DEB - 1);
                ps2_clk = 1'b0;
            end
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input logic par,
                            input logic stop, input int nbits, input bit glitch);
        send_frame(b, par, stop, nbits, glitch);
        if (nbits < PS2_FRAME_BITS) wait_cyc(TMO + 5);
        else wait_cyc(3 * HALF);
        model_frame(b, par, stop, nbits);
        check_all(tag);
    endtask

    task automatic pop_once(input string tag);
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (mq_a.size() > 0) void'(mq_a.pop_front());
        if (mq_b.size() > 0) void'(mq_b.pop_front());
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        while (mq_a.size() > 0 || mq_b.size() > 0) pop_once(tag);
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    initial begin
        logic [7:0] b;
        int kind;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(2);
        check_all("reset");

        do_frame("frame 1C", 8'h1C, 1'b0, 1'b1, 11, 1'b0);
        drain("pop 1C");

        do_frame("bad parity F0", 8'hF0, 1'b0, 1'b1, 11, 1'b0);
        drain("pop F0");

        do_frame("bad stop 5A", 8'h5A, good_par(8'h5A), 1'b0, 11, 1'b0);
        do_frame("frame 12", 8'h12, good_par(8'h12), 1'b1, 11, 1'b0);
        drain("pop 12");

        for (int k = 1; k <= 5; k++) begin
            b = 8'(k);
            do_frame("fill", b, good_par(b), 1'b1, 11, 1'b0);
        end
        drain("pop fill");
        pop_once("pop empty");

        do_frame("timeout", 8'h07, 1'b0, 1'b1, 4, 1'b0);
        do_frame("frame 29", 8'h29, good_par(8'h29), 1'b1, 11, 1'b0);
        drain("pop 29");

        do_frame("glitch 1C", 8'h1C, 1'b0, 1'b1, 11, 1'b1);

        do_frame("pre-reset 44", 8'h44, good_par(8'h44), 1'b1, 11, 1'b0);
        send_frame(8'h33, good_par(8'h33), 1'b1, 5, 1'b0);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        mq_a.delete();
        mq_b.delete();
        wait_cyc(2);
        check_all("reset mid-frame");
        do_frame("post-reset 55", 8'h55, good_par(8'h55), 1'b1, 11, 1'b0);
        drain("pop 55");

        for (int n = 0; n < 25; n++) begin
            b = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) do_frame("rand stop", b, good_par(b), 1'b0, 11, 1'b0);
            else if (kind == 1) do_frame("rand parity", b, ~good_par(b), 1'b1, 11, 1'b0);
            else if (kind == 2)
                do_frame("rand timeout", b, good_par(b), 1'b1, int'($urandom_range(1, 10)), 1'b0);
            else do_frame("rand good", b, good_par(b), 1'b1, 11, bit'($urandom_range(0, 1)));
            for (int p = int'($urandom_range(0, 2)); p > 0; p--) pop_once("rand pop");
        end
        drain("final drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
